// File: rtl/cart_mapper_pkg.sv
// ============================================================================
// Module : cart_mapper_pkg
// Brief  : Shared types and constants for the MSX cartridge mapper slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cart_mapper_pkg;

  typedef enum logic [2:0] {
    MODE_LINEAR  = 3'd0,
    MODE_KONAMI  = 3'd1,
    MODE_SCC     = 3'd2,
    MODE_ASCII8  = 3'd3,
    MODE_ASCII16 = 3'd4,
    MODE_RTYPE   = 3'd5
  } mapper_mode_e;

  typedef enum logic [2:0] {
    LD_IDLE = 3'd0,
    LD_LOAD = 3'd1,
    LD_WAIT = 3'd2,
    LD_SIZE = 3'd3,
    LD_DONE = 3'd4
  } loader_state_e;

  localparam logic [15:0] c_win_lo = 16'h4000;
  localparam logic [15:0] c_win_hi = 16'hC000;

  // Bank reset values packed one byte per bank, bank0 in the low byte.
  localparam logic [31:0] c_rst_linear  = 32'h0000_0000;
  localparam logic [31:0] c_rst_konami  = 32'h0302_0100;
  localparam logic [31:0] c_rst_scc     = 32'h0302_0100;
  localparam logic [31:0] c_rst_ascii8  = 32'h0000_0000;
  localparam logic [31:0] c_rst_ascii16 = 32'h0000_0000;
  localparam logic [31:0] c_rst_rtype   = 32'h0000_000F;

  function automatic mapper_mode_e decode_mode(input logic [2:0] m);
    case (m)
      3'd1:    return MODE_KONAMI;
      3'd2:    return MODE_SCC;
      3'd3:    return MODE_ASCII8;
      3'd4:    return MODE_ASCII16;
      3'd5:    return MODE_RTYPE;
      default: return MODE_LINEAR;
    endcase
  endfunction

  function automatic logic [31:0] bank_rst_vals(input mapper_mode_e m);
    case (m)
      MODE_KONAMI:  return c_rst_konami;
      MODE_SCC:     return c_rst_scc;
      MODE_ASCII8:  return c_rst_ascii8;
      MODE_ASCII16: return c_rst_ascii16;
      MODE_RTYPE:   return c_rst_rtype;
      default:      return c_rst_linear;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/cart_rom_loader.sv
// ============================================================================
// Module : cart_rom_loader
// Brief  : ROM download sequencer; tracks the highest byte written and sizes
//          the image to a power of two once the download ends.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cart_rom_loader
  import cart_mapper_pkg::*;
#(
  parameter int ADDR_W = 25
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ioctl_isROM,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic              ram_ready,
  output logic              ioctl_wait,
  output logic              busy,
  output logic              idle,
  output logic              load_done,
  output logic [ADDR_W-1:0] rom_size
);

  loader_state_e     r_state;
  loader_state_e     w_next;
  logic              r_isrom_q;
  logic [ADDR_W-1:0] r_max_addr;
  logic [ADDR_W-1:0] r_rom_size;
  logic [ADDR_W-1:0] w_size;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= LD_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      LD_IDLE: if (ioctl_isROM && !r_isrom_q) w_next = LD_LOAD;
      LD_LOAD: begin
        if (ioctl_wr)          w_next = LD_WAIT;
        else if (!ioctl_isROM) w_next = LD_SIZE;
      end
      // A download that ends mid-write still waits for the RAM to accept it.
      LD_WAIT: if (ram_ready) w_next = ioctl_isROM ? LD_LOAD : LD_SIZE;
      LD_SIZE: w_next = LD_DONE;
      LD_DONE: w_next = LD_IDLE;
      default: w_next = LD_IDLE;
    endcase
  end

  always_comb begin
    ioctl_wait = (r_state == LD_WAIT) && !ram_ready;
    busy       = (r_state == LD_LOAD) || (r_state == LD_WAIT);
    idle       = (r_state == LD_IDLE);
    load_done  = (r_state == LD_DONE);
  end

  // Smallest power of two strictly above max_addr, clamped to [2^13, 2^(ADDR_W-1)].
  always_comb begin
    w_size             = '0;
    w_size[ADDR_W-1]   = 1'b1;
    for (int k = ADDR_W - 2; k >= 13; k--) begin
      if ((r_max_addr >> k) == '0) begin
        w_size    = '0;
        w_size[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_isrom_q  <= 1'b0;
      r_max_addr <= '0;
      r_rom_size <= ADDR_W'(32'h8000);
    end else begin
      r_isrom_q <= ioctl_isROM;
      if (r_state == LD_IDLE && w_next == LD_LOAD)
        r_max_addr <= '0;
      else if (r_state == LD_LOAD && ioctl_wr && ioctl_addr > r_max_addr)
        r_max_addr <= ioctl_addr;
      if (r_state == LD_SIZE)
        r_rom_size <= w_size;
    end
  end

  assign rom_size = r_rom_size;

endmodule

`default_nettype wire

// File: rtl/cart_mapper_gen.sv
// ============================================================================
// Module : cart_mapper_gen
// Brief  : MSX mega-ROM mapper (linear/Konami/SCC/ASCII8/ASCII16/R-Type).
//          Optional SRAM paging in ASCII modes: define CART_MAPPER_SRAM_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cart_mapper_gen
  import cart_mapper_pkg::*;
#(
  parameter int ADDR_W  = 25,
  parameter int BANK_W  = 8,
  parameter int SRAM_AW = 13
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         mode,
  input  logic [15:0]        addr,
  input  logic [7:0]         d_from_cpu,
  input  logic               wr,
  input  logic               cs,
  input  logic               ioctl_isROM,
  input  logic               ioctl_wr,
  input  logic [ADDR_W-1:0]  ioctl_addr,
  input  logic               ram_ready,
  output logic               ioctl_wait,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               rom_oe,
  output logic [ADDR_W-1:0]  rom_size,
  output logic               load_done,
  output logic               sram_sel,
  output logic               sram_we,
  output logic [SRAM_AW-1:0] sram_addr
);

  mapper_mode_e      w_mode;
  mapper_mode_e      r_mode_q;
  logic [31:0]       w_rst_vals;
  logic              r_wr_q;
  logic              w_wstb;
  logic              w_ld_busy;
  logic              w_ld_idle;
  logic              w_ld_done;
  logic [BANK_W-1:0] r_bank [4];
  logic [3:0]        w_bank_we;
  logic [BANK_W-1:0] w_bank_wd;
  logic [2:0]        w_page_raw;
  logic [1:0]        w_page_idx;
  logic [BANK_W-1:0] w_bank_sel;
  logic              w_is16;
  logic              w_linear;
  logic              w_in_win;
  logic              w_sram_hit;
  logic [ADDR_W-1:0] w_map_addr;

  assign w_mode     = decode_mode(mode);
  assign w_rst_vals = bank_rst_vals(w_mode);
  assign w_wstb     = cs & wr & ~r_wr_q & w_ld_idle;

  cart_rom_loader #(
    .ADDR_W (ADDR_W)
  ) u_loader (
    .clk         (clk),
    .reset_n     (reset_n),
    .ioctl_isROM (ioctl_isROM),
    .ioctl_wr    (ioctl_wr),
    .ioctl_addr  (ioctl_addr),
    .ram_ready   (ram_ready),
    .ioctl_wait  (ioctl_wait),
    .busy        (w_ld_busy),
    .idle        (w_ld_idle),
    .load_done   (w_ld_done),
    .rom_size    (rom_size)
  );

  assign load_done = w_ld_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_q   <= 1'b0;
      r_mode_q <= w_mode;
    end else begin
      r_wr_q   <= wr;
      r_mode_q <= w_mode;
    end
  end

  always_comb begin
    w_bank_we = '0;
    w_bank_wd = BANK_W'(d_from_cpu);
    case (w_mode)
      MODE_KONAMI: begin
        case (addr[15:11])
          5'b01100: w_bank_we[1] = 1'b1;
          5'b10000: w_bank_we[2] = 1'b1;
          5'b10100: w_bank_we[3] = 1'b1;
          default:  ;
        endcase
      end
      MODE_SCC: begin
        case (addr[15:11])
          5'b01010: w_bank_we[0] = 1'b1;
          5'b01110: w_bank_we[1] = 1'b1;
          5'b10010: w_bank_we[2] = 1'b1;
          5'b10110: w_bank_we[3] = 1'b1;
          default:  ;
        endcase
      end
      // 6000/6800/7000/7800 map straight onto addr[12:11].
      MODE_ASCII8: if (addr[15:13] == 3'b011) w_bank_we[addr[12:11]] = 1'b1;
      MODE_ASCII16: begin
        case (addr[15:11])
          5'b01100: w_bank_we[0] = 1'b1;
          5'b01110: w_bank_we[1] = 1'b1;
          default:  ;
        endcase
      end
      MODE_RTYPE: begin
        if (addr[15:12] == 4'h7) begin
          w_bank_we[1] = 1'b1;
          w_bank_wd    = BANK_W'(d_from_cpu & (d_from_cpu[4] ? 8'h17 : 8'h0F));
        end
      end
      default: ;
    endcase
  end

  // Mode changes and completed downloads both restore the mode's reset banks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) r_bank[i] <= BANK_W'(w_rst_vals[8*i +: 8]);
    end else if (w_mode != r_mode_q || w_ld_done) begin
      for (int i = 0; i < 4; i++) r_bank[i] <= BANK_W'(w_rst_vals[8*i +: 8]);
    end else if (w_wstb) begin
      for (int i = 0; i < 4; i++) if (w_bank_we[i]) r_bank[i] <= w_bank_wd;
    end
  end

  assign w_page_raw = addr[15:13] - 3'd2;
  assign w_is16     = (w_mode == MODE_ASCII16) || (w_mode == MODE_RTYPE);
  assign w_linear   = (w_mode == MODE_LINEAR);
  assign w_page_idx = w_is16 ? {1'b0, addr[15]} : w_page_raw[1:0];
  assign w_bank_sel = r_bank[w_page_idx];
  assign w_in_win   = (addr >= c_win_lo) && (addr < c_win_hi);

  always_comb begin
    if (w_linear)    w_map_addr = ADDR_W'(addr);
    else if (w_is16) w_map_addr = ADDR_W'({w_bank_sel, addr[13:0]});
    else             w_map_addr = ADDR_W'({w_bank_sel, addr[12:0]});
  end

  assign mem_addr = w_ld_busy ? ioctl_addr : (w_map_addr & (rom_size - ADDR_W'(1)));
  assign rom_oe   = cs & (w_linear | w_in_win) & ~w_sram_hit;

`ifdef CART_MAPPER_SRAM_EN
  // Top bank bit pages SRAM into the 8000-BFFF half in the ASCII modes.
  assign w_sram_hit = ((w_mode == MODE_ASCII8) || (w_mode == MODE_ASCII16)) &&
                      (addr[15:14] == 2'b10) && w_bank_sel[BANK_W-1];
  assign sram_sel   = reset_n & cs & w_sram_hit;
  assign sram_we    = sram_sel & w_wstb;
  assign sram_addr  = addr[SRAM_AW-1:0];
`else
  assign w_sram_hit = 1'b0;
  assign sram_sel   = 1'b0;
  assign sram_we    = 1'b0;
  assign sram_addr  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cart_mapper_gen.sv
// ============================================================================
// Module : tb_cart_mapper_gen
// Brief  : Directed self-checking bench for cart_mapper_gen.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cart_mapper_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  mode;
  logic [15:0] addr;
  logic [7:0]  d_from_cpu;
  logic        wr, cs;
  logic        ioctl_isROM, ioctl_wr, ram_ready;
  logic [24:0] ioctl_addr;
  logic        ioctl_wait, rom_oe, load_done, sram_sel, sram_we;
  logic [24:0] mem_addr, rom_size;
  logic [12:0] sram_addr;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  cart_mapper_gen dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mode        (mode),
    .addr        (addr),
    .d_from_cpu  (d_from_cpu),
    .wr          (wr),
    .cs          (cs),
    .ioctl_isROM (ioctl_isROM),
    .ioctl_wr    (ioctl_wr),
    .ioctl_addr  (ioctl_addr),
    .ram_ready   (ram_ready),
    .ioctl_wait  (ioctl_wait),
    .mem_addr    (mem_addr),
    .rom_oe      (rom_oe),
    .rom_size    (rom_size),
    .load_done   (load_done),
    .sram_sel    (sram_sel),
    .sram_we     (sram_we),
    .sram_addr   (sram_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [24:0] exp);
    addr = a; cs = 1'b1; wr = 1'b0;
    #1;
    chk({tag, " mem_addr"}, 32'(mem_addr), 32'(exp));
    chk({tag, " rom_oe"}, 32'(rom_oe), 32'd1);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    tick();
    addr = a; d_from_cpu = d; cs = 1'b1; wr = 1'b1;
    tick();
    wr = 1'b0; cs = 1'b0;
    tick();
  endtask

  task automatic dl_start();
    tick();
    ioctl_isROM = 1'b1;
    tick();
  endtask

  task automatic dl_byte(input logic [24:0] a, input int nwait);
    int n;
    ioctl_addr = a; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    #1;
    chk("dl mem_addr", 32'(mem_addr), 32'(a));
    n = 0;
    for (int c = 0; c < nwait; c++) begin
      if (ioctl_wait) n++;
      tick();
    end
    ram_ready = 1'b1;
    #1;
    if (ioctl_wait) n++;
    tick();
    ram_ready = 1'b0;
    chk("dl wait cycles", 32'(n), 32'(nwait));
  endtask

  task automatic dl_finish(input logic [24:0] exp_size);
    int n;
    ioctl_isROM = 1'b0;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (load_done) n++;
    end
    chk("load_done pulses", 32'(n), 32'd1);
    chk("rom_size", 32'(rom_size), 32'(exp_size));
  endtask

  initial begin
    int n;
    reset_n = 1'b0; mode = 3'd0; addr = 16'h0; d_from_cpu = 8'h0;
    wr = 1'b0; cs = 1'b0; ioctl_isROM = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ram_ready = 1'b0;
    #12;
    chk("rst ioctl_wait", 32'(ioctl_wait), 32'd0);
    chk("rst load_done", 32'(load_done), 32'd0);
    chk("rst rom_size", 32'(rom_size), 32'h8000);
    chk("rst sram_sel", 32'(sram_sel), 32'd0);
    chk("rst sram_we", 32'(sram_we), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Linear mode, masked by the default 32 KB size
    rd("linear 1234", 16'h1234, 25'h1234);
    rd("linear C123", 16'hC123, 25'h4123);
    cs = 1'b0; #1;
    chk("linear cs=0 rom_oe", 32'(rom_oe), 32'd0);
    mode = 3'd6; tick();
    rd("mode6 as linear", 16'hC123, 25'h4123);
    mode = 3'd0; tick();

    // Downloads: 0x6000-byte image, minimum size, saturation, 128 KB
    dl_start();
    for (int i = 0; i < 6; i++) dl_byte(25'(i * 32'h1000), 3);
    dl_byte(25'h5FFF, 3);
    dl_finish(25'h8000);

    dl_start(); dl_byte(25'h10, 1);       dl_finish(25'h2000);
    dl_start(); dl_byte(25'h1FFFFFF, 1);  dl_finish(25'h1000000);
    dl_start(); dl_byte(25'h0, 2); dl_byte(25'h1FFFF, 1); dl_finish(25'h20000);

    // ASCII8
    mode = 3'd3; tick(); tick();
    cpu_write(16'h7000, 8'h05);
    rd("ascii8 8123", 16'h8123, 25'h0A123);
    rd("ascii8 4123", 16'h4123, 25'h00123);
    rd("ascii8 BFFF", 16'hBFFF, 25'h01FFF);
    addr = 16'hC000; #1;
    chk("ascii8 C000 rom_oe", 32'(rom_oe), 32'd0);
    addr = 16'h3FFF; #1;
    chk("ascii8 3FFF rom_oe", 32'(rom_oe), 32'd0);

    // Konami SCC
    mode = 3'd2; tick(); tick();
    rd("scc A000 rst", 16'hA000, 25'h06000);
    rd("scc 5000 rst", 16'h5000, 25'h01000);
    cpu_write(16'hB000, 8'h1F);
    rd("scc A000 wrap", 16'hA000, 25'h1E000);

    // Konami: held write counts once, then a write racing a mode change
    mode = 3'd1; cs = 1'b0; tick(); tick();
    addr = 16'h6000; d_from_cpu = 8'h07; cs = 1'b1; wr = 1'b1;
    tick();
    d_from_cpu = 8'h09;
    repeat (4) tick();
    wr = 1'b0; cs = 1'b0;
    tick();
    rd("konami bank1 once", 16'h6000, 25'h0E000);
    rd("konami bank0 fixed", 16'h4000, 25'h00000);
    tick();
    mode = 3'd3; addr = 16'h6000; d_from_cpu = 8'h0B; cs = 1'b1; wr = 1'b1;
    tick();
    wr = 1'b0; cs = 1'b0;
    tick();
    rd("mode change drops wr", 16'h4000, 25'h00000);
    cpu_write(16'h6000, 8'h0B);
    rd("ascii8 bank0 write", 16'h4000, 25'h16000);

    // ASCII16
    mode = 3'd4; cs = 1'b0; tick(); tick();
    cpu_write(16'h7000, 8'h03);
    rd("ascii16 9ABC", 16'h9ABC, 25'h0DABC);
    rd("ascii16 4ABC", 16'h4ABC, 25'h00ABC);
    cpu_write(16'h7000, 8'h80);
    tick();
    addr = 16'h9ABC; d_from_cpu = 8'h55; cs = 1'b1; wr = 1'b1;
    #1;
`ifdef CART_MAPPER_SRAM_EN
    chk("sram sel", 32'(sram_sel), 32'd1);
    chk("sram we", 32'(sram_we), 32'd1);
    chk("sram addr", 32'(sram_addr), 32'h1ABC);
    chk("sram rom_oe", 32'(rom_oe), 32'd0);
`else
    chk("no-sram we", 32'(sram_we), 32'd0);
    chk("no-sram sel", 32'(sram_sel), 32'd0);
    chk("no-sram rom_oe", 32'(rom_oe), 32'd1);
    chk("no-sram mem_addr", 32'(mem_addr), 32'h1ABC);
`endif
    tick();
    wr = 1'b0; cs = 1'b0;
    cpu_write(16'h7000, 8'h03);
    dl_start(); dl_byte(25'hFFFFF, 1); dl_finish(25'h100000);
    rd("done reloads banks", 16'h9ABC, 25'h01ABC);

    // R-Type with a 1 MB image
    mode = 3'd5; cs = 1'b0; tick(); tick();
    rd("rtype page0", 16'h4000, 25'h3C000);
    rd("rtype page1 rst", 16'h8000, 25'h00000);
    cpu_write(16'h7000, 8'h1F);
    rd("rtype 1F->17", 16'h8000, 25'h5C000);
    cpu_write(16'h7FFF, 8'h0E);
    rd("rtype 0E->0E", 16'hBFFF, 25'h3BFFF);

    // Reset in the middle of a download
    cs = 1'b0;
    dl_start();
    ioctl_addr = 25'h100; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    #1;
    chk("pre-reset wait", 32'(ioctl_wait), 32'd1);
    reset_n = 1'b0; ioctl_isROM = 1'b0;
    #1;
    chk("abort ioctl_wait", 32'(ioctl_wait), 32'd0);
    chk("abort rom_size", 32'(rom_size), 32'h8000);
    chk("abort load_done", 32'(load_done), 32'd0);
    tick();
    reset_n = 1'b1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (load_done) n++;
    end
    chk("abort no load_done", 32'(n), 32'd0);
    chk("abort rom_size kept", 32'(rom_size), 32'h8000);
    rd("rtype after reset", 16'h4000, 25'h04000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cart_mapper_gen.md
CART_MAPPER_GEN -- requirements
Module: cart_mapper_gen

Interface
REQ-001 Parameter ADDR_W, default 25: width of the ROM/RAM byte address.
REQ-002 Parameter BANK_W, default 8: width of each bank register.
REQ-003 Parameter SRAM_AW, default 13: width of the cartridge SRAM address.
REQ-004 Ports: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- mode  in  3  mapper select: 0 linear, 1 Konami, 2 Konami SCC, 3 ASCII8, 4 ASCII16, 5 R-Type, 6-7 treated as 0
- addr  in  16  CPU address
- d_from_cpu  in  8  CPU write data
- wr  in  1  CPU write, level
- cs  in  1  slot select, active-high
- ioctl_isROM  in  1  ROM download active
- ioctl_wr  in  1  download byte strobe
- ioctl_addr  in  ADDR_W  download byte address
- ram_ready  in  1  backing RAM accepted the write
- ioctl_wait  out  1  stall the download source
- mem_addr  out  ADDR_W  backing-memory address
- rom_oe  out  1  CPU access hits the ROM window
- rom_size  out  ADDR_W  detected image size, power of two
- load_done  out  1  one-cycle pulse at the end of a download
- sram_sel, sram_we  out  1 each  SRAM select and write
- sram_addr  out  SRAM_AW  SRAM address

Function
REQ-005 Write strobe: wstb = cs & wr & ~wr_q, where wr_q is wr registered. Bank registers update on the clock edge where wstb=1. Strobes are ignored while the loader is not IDLE.
REQ-006 There are four 8 KB pages, 4000-BFFF, page index = addr[15:13]-2. 16 KB modes use two pages: 4000-7FFF and 8000-BFFF.
REQ-007 Konami: bank0 is fixed at 0. Writes to 6000-67FF, 8000-87FF and A000-A7FF load bank1, bank2 and bank3. Reset values are 0,1,2,3.
REQ-008 Konami SCC: writes to 5000-57FF, 7000-77FF, 9000-97FF and B000-B7FF load bank0-3. Reset values are 0,1,2,3.
REQ-009 ASCII8: writes to 6000, 6800, 7000 and 7800 (each 2 KB) load bank0-3. All banks reset to 0.
REQ-010 ASCII16: writes to 6000-67FF and 7000-77FF load page0 and page1. Both reset to 0.
REQ-011 R-Type: page0 is fixed at 0x0F. Writes to 7000-7FFF load page1 = d & (d[4] ? 0x17 : 0x0F). Page1 resets to 0.
REQ-012 mem_addr, 8 KB modes: {bank, addr[12:0]} & (rom_size-1).
REQ-013 mem_addr, 16 KB modes: {bank, addr[13:0]} & (rom_size-1).
REQ-014 mem_addr, linear mode: addr & (rom_size-1). mem_addr is combinational from the registered banks.
REQ-015 rom_oe = cs & (linear ? 1 : addr in 4000-BFFF). When rom_oe=0, mem_addr is don't-care.
REQ-016 A change of mode reloads all bank registers with the new mode's reset values on the next edge. A wstb in that same cycle is dropped.
REQ-017 Loader FSM states: IDLE, LOAD, WAIT, SIZE, DONE.
- IDLE to LOAD when ioctl_isROM rises; max_addr is cleared.
- LOAD to WAIT on ioctl_wr; max_addr updates to ioctl_addr when that is larger.
- WAIT to LOAD once ram_ready=1.
- LOAD to SIZE when ioctl_isROM=0.
- If ioctl_isROM falls during WAIT, the FSM stays in WAIT until ram_ready=1, then goes to SIZE.
- SIZE to DONE after one cycle. DONE to IDLE after one cycle.
REQ-018 ioctl_wait = (state==WAIT) & ~ram_ready.
REQ-019 During LOAD and WAIT, mem_addr = ioctl_addr.
REQ-020 In SIZE, rom_size is set to the smallest power of two >= max_addr+1, minimum 0x2000, saturating at 2^(ADDR_W-1).
REQ-021 In DONE, load_done=1 for one cycle and all bank registers reload their reset values.

Reset
REQ-022 reset_n low asynchronously sets:
- loader FSM to IDLE; wr_q, max_addr, load_done, ioctl_wait, sram_sel and sram_we to 0
- rom_size to 0x8000
- bank registers to the reset values of the current mode
REQ-023 A reset asserted mid-download aborts the download. rom_size stays 0x8000 and no load_done is generated.

Configuration
REQ-024 With CART_MAPPER_SRAM_EN defined, in ASCII8 and ASCII16 a bank value with bit BANK_W-1 set on a page in 8000-BFFF maps that page to SRAM. Then:
- sram_sel = cs & page hit
- sram_we = sram_sel & wstb
- sram_addr = addr[SRAM_AW-1:0]
- rom_oe = 0 for that access
REQ-025 Without CART_MAPPER_SRAM_EN, the sram_* outputs are tied to 0 and bit BANK_W-1 is an ordinary bank bit.

Structure
REQ-026 Package cart_mapper_pkg holds:
- the mode enum
- per-mode bank reset-value constants
- page window constants (4000, C000)
- loader state enum
REQ-027 The loader FSM and size computation form sub-module cart_rom_loader. Bank decoding and address generation stay in the top module.

Verification
REQ-028 Download of 0x6000 bytes with ram_ready delayed 3 cycles per byte -> ioctl_wait high 3 cycles per byte; rom_size=0x8000; one load_done pulse.
REQ-029 ASCII8, write 0x05 to 7000 then read 8123 -> mem_addr = 0x0A123 with rom_size=0x20000.
REQ-030 Konami SCC, write 0x1F to B000 with rom_size=0x20000 -> access A000 gives mem_addr 0x1E000 (wrapped by the mask).
REQ-031 wr held high 5 cycles at 6000 in Konami mode -> exactly one bank1 update; a mode change in the same cycle drops the write.
REQ-032 reset_n pulsed low during WAIT -> IDLE, ioctl_wait=0, rom_size=0x8000, no load_done.
REQ-033 CART_MAPPER_SRAM_EN, ASCII16, write 0x80 to 7000 then write 0x55 at 9ABC -> sram_we=1, sram_addr=0x1ABC, rom_oe=0.
